// File: rtl/serial_sub_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
// Signed-overflow output is enabled with SERIAL_SUB_OVF_EN.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } sub_state_t;

    localparam int DEFAULT_N = 8;

endpackage

// File: rtl/serial_subtractor_full_sub_bit.sv
// One-bit full subtractor: d = a - b - br, with borrow out.
// Pure combinational slice used by the serial datapath.
module full_sub_bit (
    input  logic a,
    input  logic b,
    input  logic br,
    output logic d,
    output logic br_out
);

    assign d      = a ^ b ^ br;
    assign br_out = (~a & b) | (~(a ^ b) & br);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial N-bit subtractor, LSB first, start/busy/done handshake.
// Define SERIAL_SUB_OVF_EN to add the registered signed-overflow port ovf.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int N = DEFAULT_N
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         bin,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] diff,
    output logic         bout
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic         ovf
`endif
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;

    sub_state_t    state;
    logic [CW-1:0] cnt;
    logic [N-1:0]  sa;
    logic [N-1:0]  sb;
    logic [N-1:0]  res;
    logic [N-1:0]  res_nx;
    logic          br;
    logic          d;
    logic          br_nx;
    logic          last;

`ifdef SERIAL_SUB_OVF_EN
    logic a_msb;
    logic b_msb;
`endif

    full_sub_bit u_bit (
        .a     (sa[0]),
        .b     (sb[0]),
        .br    (br),
        .d     (d),
        .br_out(br_nx)
    );

    // New bit enters at the MSB so the LSB-first stream lands in place.
    always_comb begin
        res_nx        = res >> 1;
        res_nx[N-1]   = d;
    end

    assign last = (cnt == CW'(N - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            sa    <= '0;
            sb    <= '0;
            res   <= '0;
            br    <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            diff  <= '0;
            bout  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            ovf   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        sa    <= a;
                        sb    <= b;
                        br    <= bin;
                        cnt   <= '0;
                        res   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
`ifdef SERIAL_SUB_OVF_EN
                        a_msb <= a[N-1];
                        b_msb <= b[N-1];
`endif
                    end
                end
                RUN: begin
                    sa  <= sa >> 1;
                    sb  <= sb >> 1;
                    br  <= br_nx;
                    res <= res_nx;
                    cnt <= cnt + 1'b1;
                    if (last) begin
                        diff  <= res_nx;
                        bout  <= br_nx;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
`ifdef SERIAL_SUB_OVF_EN
                        ovf   <= (a_msb ^ b_msb) & (res_nx[N-1] ^ a_msb);
`endif
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: N=8 instance with random and
// directed operands, plus an N=1 instance checked exhaustively.
module tb_serial_subtractor;

    localparam int N = 8;

    typedef struct {
        logic [7:0] diff;
        logic       bout;
        logic       ovf;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       bin = 1'b0;
    logic       busy;
    logic       done;
    logic [7:0] diff;
    logic       bout;

    logic       s1_start = 1'b0;
    logic [0:0] s1_a = '0;
    logic [0:0] s1_b = '0;
    logic       s1_bin = 1'b0;
    logic       s1_busy;
    logic       s1_done;
    logic [0:0] s1_diff;
    logic       s1_bout;

`ifdef SERIAL_SUB_OVF_EN
    logic ovf;
    logic s1_ovf;
`endif

    int tests = 0;
    int fails = 0;
    exp_t sbq[$];

    always #5 clk = ~clk;

    serial_subtractor #(.N(N)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .a    (a),
        .b    (b),
        .bin  (bin),
        .busy (busy),
        .done (done),
        .diff (diff),
        .bout (bout)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf  (ovf)
`endif
    );

    serial_subtractor #(.N(1)) dut1 (
        .clk  (clk),
        .rst  (rst),
        .start(s1_start),
        .a    (s1_a),
        .b    (s1_b),
        .bin  (s1_bin),
        .busy (s1_busy),
        .done (s1_done),
        .diff (s1_diff),
        .bout (s1_bout)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf  (s1_ovf)
`endif
    );

    // Reference: plain integer arithmetic on the whole operands.
    function automatic exp_t model(input int av, input int bv, input int bi);
        exp_t e;
        int   r;
        r      = av - bv - bi;
        e.diff = 8'(r & 255);
        e.bout = (av < bv + bi);
        e.ovf  = ((av >> 7) != (bv >> 7)) && ((r & 128) != (av & 128));
        return e;
    endfunction

    task automatic chk(input string nm, input int got, input int want);
        tests++;
        if (got != want) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && done) begin
            tests++;
            if (sbq.size() == 0) begin
                fails++;
                $display("FAIL unexpected_done: diff %0d with empty scoreboard", diff);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                if (diff !== e.diff || bout !== e.bout) begin
                    fails++;
                    $display("FAIL result: got diff=%0d bout=%0d expected diff=%0d bout=%0d",
                             diff, bout, e.diff, e.bout);
                end
`ifdef SERIAL_SUB_OVF_EN
                if (ovf !== e.ovf) begin
                    fails++;
                    $display("FAIL ovf: got %0d expected %0d", ovf, e.ovf);
                end
`endif
            end
        end
    end

    task automatic do_op(input logic [7:0] av, input logic [7:0] bv, input logic bi);
        int  bc;
        bit  seen;
        @(negedge clk);
        a = av; b = bv; bin = bi; start = 1'b1;
        @(posedge clk);
        sbq.push_back(model(av, bv, bi));
        @(negedge clk);
        start = 1'b0;
        a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
        bc = 0;
        seen = 0;
        for (int i = 0; i < N + 4; i++) begin
            if (done) begin
                seen = 1;
                break;
            end
            if (busy) bc++;
            @(negedge clk);
        end
        chk("done_seen", int'(seen), 1);
        chk("busy_cycles", bc, N);
        @(negedge clk);
        chk("done_pulse_width", int'(done), 0);
    endtask

    task automatic op1(input logic av, input logic bv, input logic bi);
        exp_t e;
        int   r;
        r = int'(av) - int'(bv) - int'(bi);
        @(negedge clk);
        s1_a = av; s1_b = bv; s1_bin = bi; s1_start = 1'b1;
        @(negedge clk);
        s1_start = 1'b0;
        chk("n1_busy", int'(s1_busy), 1);
        chk("n1_done_early", int'(s1_done), 0);
        @(negedge clk);
        chk("n1_done", int'(s1_done), 1);
        chk("n1_diff", int'(s1_diff), r & 1);
        chk("n1_bout", int'(s1_bout), int'(int'(av) < int'(bv) + int'(bi)));
        e = model(0, 0, 0);
`ifdef SERIAL_SUB_OVF_EN
        chk("n1_ovf", int'(s1_ovf), int'((av != bv) && ((r & 1) != int'(av))));
`endif
        @(negedge clk);
        chk("n1_done_clear", int'(s1_done), 0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_diff", int'(diff), 0);
        chk("rst_bout", int'(bout), 0);

        do_op(8'd5, 8'd1, 1'b0);
        do_op(8'd0, 8'd1, 1'b0);
        do_op(8'd254, 8'd6, 1'b1);
        do_op(8'd7, 8'd6, 1'b1);
        do_op(8'd6, 8'd6, 1'b1);
        do_op(8'd0, 8'd0, 1'b1);
        do_op(8'd255, 8'd255, 1'b0);
        do_op(8'h80, 8'd1, 1'b0);
        do_op(8'h10, 8'd1, 1'b0);
        for (int i = 0; i < 30; i++)
            do_op(8'($urandom), 8'($urandom), 1'($urandom));

        // start held high with fresh operands every cycle
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
            start = 1'b1;
            @(posedge clk);
            if (c % (N + 2) == 0)
                sbq.push_back(model(int'(a), int'(b), int'(bin)));
        end
        @(negedge clk);
        start = 1'b0;
        repeat (N + 4) @(negedge clk);
        chk("held_start_drained", sbq.size(), 0);

        // reset in the middle of a run
        @(negedge clk);
        a = 8'd200; b = 8'd3; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk("pre_abort_busy", int'(busy), 1);
        rst = 1'b1;
        #1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_diff", int'(diff), 0);
        chk("abort_bout", int'(bout), 0);
        chk("abort_done", int'(done), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (N + 3) @(negedge clk);
        chk("abort_no_result", sbq.size(), 0);
        do_op(8'd10, 8'd2, 1'b0);

        for (int i = 0; i < 8; i++)
            op1(1'(i >> 2), 1'(i >> 1), 1'(i));

        chk("scoreboard_empty", sbq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
